// File: rtl/game_pkg.sv
// Shared definitions for the game-flow sequencer: state encoding, widths and
// the default play-button geometry.
package game_pkg;

  localparam int unsigned BTN_W   = 11;
  localparam int unsigned SEC_W   = 7;
  localparam int unsigned SCORE_W = 8;

  localparam int unsigned DEF_PLAY_X = 380;
  localparam int unsigned DEF_PLAY_Y = 186;
  localparam int unsigned DEF_PLAY_W = 300;
  localparam int unsigned DEF_PLAY_H = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GAME  = 2'd2,
    SCORE = 2'd3
  } state_t;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1 and flags the terminal count.
// A synchronous clear restarts the second so each state gets a full first second.
module sec_tick #(
  parameter int unsigned CLK_HZ = 40_000_000
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Decoded from the count so the FSM can act on the same cycle.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/game_ctl.sv
// Game-flow sequencer: IDLE/WAIT/GAME/SCORE, play-button geometry, per-second
// countdown, WAIT timeout / SCORE hold timing and saturating hit score.
module game_ctl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 40_000_000,
  parameter int unsigned GAME_SECONDS   = 30,
  parameter int unsigned WAIT_TIMEOUT_S = 10,
  parameter int unsigned SCORE_HOLD_S   = 5,
  parameter int unsigned PLAY_X         = DEF_PLAY_X,
  parameter int unsigned PLAY_Y         = DEF_PLAY_Y,
  parameter int unsigned PLAY_W         = DEF_PLAY_W,
  parameter int unsigned PLAY_H         = DEF_PLAY_H
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               play_clicked,
  input  logic               uart_start,
  input  logic               target_hit,
  input  logic               stop_clicked,
  output logic [1:0]         state,
  output logic [BTN_W-1:0]   btn_hstart,
  output logic [BTN_W-1:0]   btn_vstart,
  output logic [BTN_W-1:0]   btn_hlength,
  output logic [BTN_W-1:0]   btn_vlength,
  output logic [SEC_W-1:0]   seconds_left,
  output logic [SCORE_W-1:0] score,
  output logic               score_done
);

  localparam logic [SEC_W-1:0]   GAME_SEC  = SEC_W'(GAME_SECONDS);
  localparam logic [SEC_W-1:0]   WAIT_LAST = SEC_W'(WAIT_TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0]   HOLD_LAST = SEC_W'(SCORE_HOLD_S - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t           st;
  state_t           nxt;
  logic             tick;
  logic             clr;
  logic [SEC_W-1:0] sec_cnt;

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .pclk (pclk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Transition decision; stop beats expiry, start beats timeout.
  always_comb begin
    nxt = st;
    case (st)
      IDLE:  if (play_clicked) nxt = WAIT;
      WAIT: begin
        if (stop_clicked)                  nxt = IDLE;
        else if (uart_start)               nxt = GAME;
        else if (tick && sec_cnt == WAIT_LAST) nxt = IDLE;
      end
      GAME: begin
        if (stop_clicked)                              nxt = IDLE;
        else if (tick && seconds_left == SEC_W'(1))    nxt = SCORE;
      end
      SCORE: if (tick && sec_cnt == HOLD_LAST) nxt = IDLE;
    endcase
    clr = (nxt != st);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      btn_hstart   <= BTN_W'(PLAY_X);
      btn_vstart   <= BTN_W'(PLAY_Y);
      btn_hlength  <= BTN_W'(PLAY_W);
      btn_vlength  <= BTN_W'(PLAY_H);
      seconds_left <= GAME_SEC;
      score        <= '0;
      score_done   <= 1'b0;
      sec_cnt      <= '0;
    end else begin
      st         <= nxt;
      score_done <= (st == GAME) && (nxt == SCORE);

      if (clr)       sec_cnt <= '0;
      else if (tick) sec_cnt <= sec_cnt + SEC_W'(1);

      // The button is only live while idle; zero geometry disables it.
      if (nxt == IDLE) begin
        btn_hstart  <= BTN_W'(PLAY_X);
        btn_vstart  <= BTN_W'(PLAY_Y);
        btn_hlength <= BTN_W'(PLAY_W);
        btn_vlength <= BTN_W'(PLAY_H);
      end else begin
        btn_hstart  <= '0;
        btn_vstart  <= '0;
        btn_hlength <= '0;
        btn_vlength <= '0;
      end

      if (nxt == SCORE)                     seconds_left <= '0;
      else if (nxt != GAME || st != GAME)   seconds_left <= GAME_SEC;
      else if (tick)                        seconds_left <= seconds_left - SEC_W'(1);

      if ((st == IDLE && play_clicked) || (st == GAME && stop_clicked)) begin
        score <= '0;
      end else if (st == GAME && target_hit && score != SCORE_MAX) begin
        score <= score + SCORE_W'(1);
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_game_ctl.sv
// Self-checking bench for game_ctl: directed scenarios plus randomized pulses
// compared against a time-in-state reference model.
module tb_game_ctl;

  localparam int unsigned CLK = 10;
  localparam int unsigned GS  = 30;
  localparam int unsigned WS  = 10;
  localparam int unsigned HS  = 5;

  logic        pclk = 1'b0;
  logic        rst;
  logic        play_clicked, uart_start, target_hit, stop_clicked;
  logic [1:0]  state;
  logic [10:0] btn_hstart, btn_vstart, btn_hlength, btn_vlength;
  logic [6:0]  seconds_left;
  logic [7:0]  score;
  logic        score_done;

  logic        play1, start1, hit1, stop1;
  logic [1:0]  state1;
  logic [10:0] bh1, bv1, bhl1, bvl1;
  logic [6:0]  secs1;
  logic [7:0]  score1;
  logic        done1;

  int checks = 0;
  int failures = 0;

  // Reference model: state, cycles spent in the current state, score, done pulse.
  int m_state, m_t, m_score, m_done;

  game_ctl #(.CLK_HZ(CLK), .GAME_SECONDS(GS), .WAIT_TIMEOUT_S(WS), .SCORE_HOLD_S(HS)) dut (
    .pclk(pclk), .rst(rst), .play_clicked(play_clicked), .uart_start(uart_start),
    .target_hit(target_hit), .stop_clicked(stop_clicked), .state(state),
    .btn_hstart(btn_hstart), .btn_vstart(btn_vstart), .btn_hlength(btn_hlength),
    .btn_vlength(btn_vlength), .seconds_left(seconds_left), .score(score),
    .score_done(score_done));

  game_ctl #(.CLK_HZ(CLK), .GAME_SECONDS(1), .WAIT_TIMEOUT_S(WS), .SCORE_HOLD_S(HS)) dut1 (
    .pclk(pclk), .rst(rst), .play_clicked(play1), .uart_start(start1),
    .target_hit(hit1), .stop_clicked(stop1), .state(state1),
    .btn_hstart(bh1), .btn_vstart(bv1), .btn_hlength(bhl1),
    .btn_vlength(bvl1), .seconds_left(secs1), .score(score1),
    .score_done(done1));

  always #5 pclk = ~pclk;

  function automatic void model_reset();
    m_state = 0; m_t = 0; m_score = 0; m_done = 0;
  endfunction

  function automatic void model_step(input logic p, input logic s, input logic h, input logic t);
    int nxt;
    nxt = m_state;
    m_done = 0;
    case (m_state)
      0: if (p) begin nxt = 1; m_score = 0; end
      1: begin
        if (t) nxt = 0;
        else if (s) nxt = 2;
        else if (m_t == WS * CLK - 1) nxt = 0;
      end
      2: begin
        if (t) begin
          nxt = 0; m_score = 0;
        end else begin
          if (h && m_score < 255) m_score = m_score + 1;
          if (m_t == GS * CLK - 1) begin nxt = 3; m_done = 1; end
        end
      end
      default: if (m_t == HS * CLK - 1) nxt = 0;
    endcase
    m_t = (nxt != m_state) ? 0 : m_t + 1;
    m_state = nxt;
  endfunction

  function automatic int exp_secs();
    case (m_state)
      0, 1:    return GS;
      2:       return GS - m_t / CLK;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_bh();
    return (m_state == 0) ? 380 : 0;
  endfunction

  // One pclk cycle on the main DUT; inputs are stable across the edge.
  task automatic tick(input logic p, input logic s, input logic h, input logic t);
    play_clicked = p; uart_start = s; target_hit = h; stop_clicked = t;
    @(posedge pclk);
    model_step(p, s, h, t);
    #1;
    play_clicked = 0; uart_start = 0; target_hit = 0; stop_clicked = 0;
  endtask

  task automatic tick1(input logic p, input logic s, input logic h);
    play1 = p; start1 = s; hit1 = h;
    @(posedge pclk);
    model_step(0, 0, 0, 0);
    #1;
    play1 = 0; start1 = 0; hit1 = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (state !== 2'd0 || btn_hstart !== 11'd380 || btn_vstart !== 11'd186 ||
        btn_hlength !== 11'd300 || btn_vlength !== 11'd100) begin
      failures++;
      $display("FAIL reset_state_btn: state=%0d btn=%0d/%0d/%0d/%0d exp 0 380/186/300/100",
               state, btn_hstart, btn_vstart, btn_hlength, btn_vlength);
    end
    checks++;
    if (seconds_left !== 7'd30 || score !== 8'd0 || score_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_counts: secs=%0d score=%0d done=%0d exp 30/0/0",
               seconds_left, score, score_done);
    end
    @(posedge pclk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_wait_timeout();
    tick(1, 0, 0, 0);
    checks++;
    if (state !== 2'd1 || btn_hstart !== 11'd0 || btn_vlength !== 11'd0) begin
      failures++;
      $display("FAIL wait_entry: state=%0d bh=%0d bvl=%0d exp 1/0/0", state, btn_hstart, btn_vlength);
    end
    for (int i = 1; i <= 100; i++) begin
      tick(0, 0, 0, 0);
      if (i == 99) begin
        checks++;
        if (state !== 2'd1) begin
          failures++;
          $display("FAIL wait_before_timeout: state=%0d exp 1", state);
        end
      end
    end
    checks++;
    if (state !== 2'd0 || btn_hstart !== 11'd380 || btn_vstart !== 11'd186 ||
        btn_hlength !== 11'd300 || btn_vlength !== 11'd100) begin
      failures++;
      $display("FAIL wait_timeout: state=%0d btn=%0d/%0d/%0d/%0d exp 0 380/186/300/100",
               state, btn_hstart, btn_vstart, btn_hlength, btn_vlength);
    end
  endtask

  task automatic test_game_and_hold();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if (state !== 2'd2 || seconds_left !== 7'd30) begin
      failures++;
      $display("FAIL game_entry: state=%0d secs=%0d exp 2/30", state, seconds_left);
    end
    for (int i = 1; i <= 300; i++) begin
      tick(0, 0, (i % 40 == 0) && (i <= 200), 0);
      if (i == 10) begin
        checks++;
        if (seconds_left !== 7'd29) begin
          failures++;
          $display("FAIL first_second: secs=%0d exp 29", seconds_left);
        end
      end
      if (i == 299) begin
        checks++;
        if (state !== 2'd2 || seconds_left !== 7'd1 || score_done !== 1'b0) begin
          failures++;
          $display("FAIL game_last_cycle: state=%0d secs=%0d done=%0d exp 2/1/0",
                   state, seconds_left, score_done);
        end
      end
    end
    checks++;
    if (state !== 2'd3 || seconds_left !== 7'd0 || score_done !== 1'b1 || score !== 8'd5) begin
      failures++;
      $display("FAIL game_expiry: state=%0d secs=%0d done=%0d score=%0d exp 3/0/1/5",
               state, seconds_left, score_done, score);
    end
    // Everything arriving during SCORE must be dropped.
    for (int j = 1; j <= 50; j++) begin
      tick(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      if (j == 1) begin
        checks++;
        if (score_done !== 1'b0) begin
          failures++;
          $display("FAIL done_one_cycle: done=%0d exp 0", score_done);
        end
      end
      if (j == 49) begin
        checks++;
        if (state !== 2'd3 || score !== 8'd5) begin
          failures++;
          $display("FAIL score_hold: state=%0d score=%0d exp 3/5", state, score);
        end
      end
    end
    checks++;
    if (state !== 2'd0 || score !== 8'd5 || btn_hstart !== 11'd380) begin
      failures++;
      $display("FAIL hold_to_idle: state=%0d score=%0d bh=%0d exp 0/5/380", state, score, btn_hstart);
    end
    tick(1, 0, 0, 0);
    checks++;
    if (state !== 2'd1 || score !== 8'd0) begin
      failures++;
      $display("FAIL replay_clears_score: state=%0d score=%0d exp 1/0", state, score);
    end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_saturate();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 300; i++) tick(0, 0, 1, 0);
    checks++;
    if (state !== 2'd3 || score !== 8'd255) begin
      failures++;
      $display("FAIL saturate: state=%0d score=%0d exp 3/255", state, score);
    end
    for (int i = 0; i < 50; i++) tick(0, 0, 0, 0);
    checks++;
    if (state !== 2'd0 || score !== 8'd255) begin
      failures++;
      $display("FAIL saturate_idle: state=%0d score=%0d exp 0/255", state, score);
    end
  endtask

  task automatic test_expiry_hit();
    tick1(1, 0, 0);
    tick1(0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      tick1(0, 0, (i == 3) || (i == 6) || (i == 10));
      if (i == 9) begin
        checks++;
        if (state1 !== 2'd2 || score1 !== 8'd2) begin
          failures++;
          $display("FAIL short_game_pre: state=%0d score=%0d exp 2/2", state1, score1);
        end
      end
    end
    checks++;
    if (state1 !== 2'd3 || score1 !== 8'd3 || done1 !== 1'b1 || secs1 !== 7'd0) begin
      failures++;
      $display("FAIL expiry_hit: state=%0d score=%0d done=%0d secs=%0d exp 3/3/1/0",
               state1, score1, done1, secs1);
    end
  endtask

  task automatic test_stop();
    logic seen_done;
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 1; i <= 150; i++) tick(0, 0, (i % 10 == 0), 0);
    checks++;
    if (state !== 2'd2 || score !== 8'd15 || seconds_left !== 7'd15) begin
      failures++;
      $display("FAIL mid_game: state=%0d score=%0d secs=%0d exp 2/15/15", state, score, seconds_left);
    end
    tick(0, 0, 1, 1);
    checks++;
    if (state !== 2'd0 || score !== 8'd0 || score_done !== 1'b0 || seconds_left !== 7'd30 ||
        btn_hstart !== 11'd380) begin
      failures++;
      $display("FAIL stop: state=%0d score=%0d done=%0d secs=%0d bh=%0d exp 0/0/0/30/380",
               state, score, score_done, seconds_left, btn_hstart);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(0, 0, 0, 0);
      if (score_done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0 || state !== 2'd0) begin
      failures++;
      $display("FAIL stop_no_done: done_seen=%0d state=%0d exp 0/0", seen_done, state);
    end
  endtask

  task automatic test_rst_mid_game();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) tick(0, 0, 1, 0);
    #2;
    rst = 1;
    #1;
    checks++;
    if (state !== 2'd0 || btn_hstart !== 11'd380 || btn_vstart !== 11'd186 ||
        btn_hlength !== 11'd300 || btn_vlength !== 11'd100 || seconds_left !== 7'd30 ||
        score !== 8'd0 || score_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: state=%0d bh=%0d secs=%0d score=%0d done=%0d exp 0/380/30/0/0",
               state, btn_hstart, seconds_left, score, score_done);
    end
    checks++;
    if (state1 !== 2'd0 || score1 !== 8'd0 || secs1 !== 7'd1 || bh1 !== 11'd380) begin
      failures++;
      $display("FAIL async_reset_short: state=%0d score=%0d secs=%0d bh=%0d exp 0/0/1/380",
               state1, score1, secs1, bh1);
    end
    @(posedge pclk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
           $urandom_range(199) == 0);
      checks++;
      if (state !== 2'(m_state) || seconds_left !== 7'(exp_secs()) || score !== 8'(m_score) ||
          score_done !== 1'(m_done) || btn_hstart !== 11'(exp_bh())) begin
        failures++;
        $display("FAIL random_c%0d: state=%0d secs=%0d score=%0d done=%0d bh=%0d exp %0d/%0d/%0d/%0d/%0d",
                 c, state, seconds_left, score, score_done, btn_hstart,
                 m_state, exp_secs(), m_score, m_done, exp_bh());
      end
    end
  endtask

  initial begin
    rst = 1;
    play_clicked = 0; uart_start = 0; target_hit = 0; stop_clicked = 0;
    play1 = 0; start1 = 0; hit1 = 0; stop1 = 0;
    model_reset();
    test_reset();
    test_wait_timeout();
    test_game_and_hold();
    test_saturate();
    test_expiry_hit();
    test_stop();
    test_rst_mid_game();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
